// File: rtl/dffram_lsu_master_pkg.sv
// rtl/dffram_lsu_master_pkg.sv - lsu_pkg: states, funct3 codes, write masks and request helpers (honours LSU_MISALIGN_TRAP_EN)
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WE_NONE    = 4'b0000;
    localparam logic [3:0] WE_BYTE    = 4'b0001;
    localparam logic [3:0] WE_HALF_LO = 4'b0011;
    localparam logic [3:0] WE_HALF_HI = 4'b1100;
    localparam logic [3:0] WE_WORD    = 4'b1111;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    // A request faults on an encoding the core cannot issue, or on misalignment when trapping is built in.
    function automatic logic req_faults(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic illegal;
        logic misaligned;
        if (we) begin
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        end
        case (f3)
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = |off;
            default:     misaligned = 1'b0;
        endcase
        return illegal | (MISALIGN_TRAP & misaligned);
    endfunction

    // Byte-lane write mask; halfwords ignore addr[0] and words ignore addr[1:0].
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return WE_BYTE << off;
            F3_H:    return off[1] ? WE_HALF_HI : WE_HALF_LO;
            F3_W:    return WE_WORD;
            default: return WE_NONE;
        endcase
    endfunction

    // Replicate the right-justified store data across every lane the mask might select.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            F3_B:    return {4{wdata[7:0]}};
            F3_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dffram_lsu_master_if.sv
// rtl/dffram_lsu_master_if.sv - core request/response and DFFRAM port bundle
interface dffram_lsu_master_if #(
    parameter int ADDRESS_LENGTH = 11,
    parameter int DATA_LENGTH    = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [2:0]                req_funct3;
    logic [31:0]               req_addr;
    logic [DATA_LENGTH-1:0]    req_wdata;
    logic                      rsp_valid;
    logic [DATA_LENGTH-1:0]    rsp_rdata;
    logic                      rsp_fault;
    logic                      mem_en;
    logic [3:0]                mem_we;
    logic [ADDRESS_LENGTH-1:0] mem_a;
    logic [DATA_LENGTH-1:0]    mem_di;
    logic [DATA_LENGTH-1:0]    mem_do;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_do,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_en, mem_we, mem_a, mem_di
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_do,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_en, mem_we, mem_a, mem_di
    );
endinterface

// File: rtl/dffram_lsu_master_load_align.sv
// rtl/dffram_lsu_master_load_align.sv - lsu_load_align: lane select and sign/zero extension of a read word
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    output logic [31:0] result_o
);
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and extend it according to the load flavour.
    always_comb begin
        shifted  = word_i >> {addr_lo_i, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {24'd0, byte_sel};
            F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result_o = {16'd0, half_sel};
            F3_W:    result_o = word_i;
            default: result_o = 32'd0;
        endcase
    end
endmodule

// File: rtl/dffram_lsu_master.sv
// rtl/dffram_lsu_master.sv - RV32I load/store initiator for the DFFRAM data memory (option: LSU_MISALIGN_TRAP_EN)
module dffram_lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDRESS_LENGTH = 11,
    parameter int DATA_LENGTH    = 32
)(
    input  logic                CLK,
    input  logic                RST_N,
    dffram_lsu_master_if.slave  bus
);
    lsu_state_e                state_q, state_d;
    logic                      we_q, we_d;
    logic [2:0]                f3_q, f3_d;
    logic [ADDRESS_LENGTH+1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0]    wdata_q, wdata_d;
    logic [DATA_LENGTH-1:0]    rdata_q, rdata_d;
    logic                      fault_q, fault_d;
    logic [31:0]               load_word;

    // Byte-address bits above the memory are dropped on purpose, so the memory aliases.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDRESS_LENGTH+2];

    lsu_load_align u_load_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .word_i    (bus.mem_do),
        .result_o  (load_word)
    );

    // State, latched request and held response registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, request capture and memory/handshake outputs.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        f3_d          = f3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = WE_NONE;
        bus.mem_a     = addr_q[ADDRESS_LENGTH+1:2];
        bus.mem_di    = store_data(f3_q, wdata_q);

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr[ADDRESS_LENGTH+1:0];
                    wdata_d = bus.req_wdata;
                    if (req_faults(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
                        // Faults skip the memory entirely and answer next cycle.
                        state_d = ST_RESP;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_ISSUE;
                        fault_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                bus.mem_en = 1'b1;
                if (we_q) begin
                    bus.mem_we = store_mask(f3_q, addr_q[1:0]);
                    rdata_d    = '0;
                    state_d    = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The memory's registered output holds the word this cycle.
                rdata_d = load_word;
                state_d = ST_RESP;
            end
            default: begin
                bus.rsp_valid = 1'b1;
                state_d       = ST_IDLE;
            end
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_fault = fault_q;

endmodule

// File: tb/tb_dffram_lsu_master.sv
// tb/tb_dffram_lsu_master.sv - scoreboard bench for dffram_lsu_master and lsu_load_align
module tb_dffram_lsu_master;
    import lsu_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [10:0] a;
        logic [3:0]  we;
        logic [31:0] di;
        int          cyc;
    } mem_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    rsp_t rsp_q[$];
    mem_t mem_q[$];
    logic [31:0] ram [2048];

    logic [2:0]  ua_f3;
    logic [1:0]  ua_off;
    logic [31:0] ua_word;
    logic [31:0] ua_res;

    dffram_lsu_master_if #(.ADDRESS_LENGTH(11), .DATA_LENGTH(32)) bus ();

    dffram_lsu_master #(.ADDRESS_LENGTH(11), .DATA_LENGTH(32)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    lsu_load_align u_align (
        .funct3_i  (ua_f3),
        .addr_lo_i (ua_off),
        .word_i    (ua_word),
        .result_o  (ua_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DFFRAM model: byte-enabled write, registered read, zero output when disabled.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) ram[bus.mem_a][8*b +: 8] <= bus.mem_di[8*b +: 8];
            bus.mem_do <= ram[bus.mem_a];
        end else begin
            bus.mem_do <= 32'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or memory access.
    always @(negedge clk) begin
        rsp_t r;
        mem_t m;
        if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, r.rdata);
                chk("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, r.fault});
                chk("rsp_cycle", cyc, r.cyc);
            end
        end
        if (bus.mem_en) begin
            if (mem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_mem_en: got mem_en=1 expected 0 (cycle %0d)", cyc);
            end else begin
                m = mem_q.pop_front();
                chk("mem_a", {21'd0, bus.mem_a}, {21'd0, m.a});
                chk("mem_we", {28'd0, bus.mem_we}, {28'd0, m.we});
                if (m.we != 4'd0) chk("mem_di", bus.mem_di, m.di);
                chk("mem_cycle", cyc, m.cyc);
            end
        end else if (bus.mem_we != 4'd0) begin
            checks++; errors++;
            $display("FAIL mem_we_idle: got %b expected 0000 (cycle %0d)", bus.mem_we, cyc);
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || mem_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got %0d pending expected 0 (cycle %0d)", rsp_q.size() + mem_q.size(), cyc);
            rsp_q.delete();
            mem_q.delete();
        end
    endtask

    // Drive one request at a negedge; ISSUE falls one cycle after, response at the fixed latency.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [10:0] exp_a, input logic [3:0] exp_we,
                         input logic [31:0] exp_di, input logic [31:0] exp_rd, input logic exp_fault,
                         input bit want_rsp);
        int lat;
        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        lat = exp_fault ? 1 : (we ? 2 : 3);
        if (!exp_fault) mem_q.push_back('{a: exp_a, we: exp_we, di: exp_di, cyc: cyc + 1});
        if (want_rsp) rsp_q.push_back('{rdata: exp_rd, fault: exp_fault, cyc: cyc + lat});
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (want_rsp) drain();
    endtask

    task automatic ua(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w, input logic [31:0] exp);
        ua_f3 = f3; ua_off = off; ua_word = w;
        #1;
        chk("align", ua_res, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        ua(F3_B,  2'd0, 32'h80FF7F01, 32'h00000001);
        ua(F3_B,  2'd1, 32'h80FF7F01, 32'h0000007F);
        ua(F3_B,  2'd2, 32'h80FF7F01, 32'hFFFFFFFF);
        ua(F3_B,  2'd3, 32'h80FF7F01, 32'hFFFFFF80);
        ua(F3_BU, 2'd3, 32'h80FF7F01, 32'h00000080);
        ua(F3_H,  2'd0, 32'h80FF7F01, 32'h00007F01);
        ua(F3_H,  2'd2, 32'h80FF7F01, 32'hFFFF80FF);
        ua(F3_HU, 2'd2, 32'h80FF7F01, 32'h000080FF);
        ua(F3_HU, 2'd3, 32'h80FF7F01, 32'h000080FF);
        ua(F3_W,  2'd0, 32'h80FF7F01, 32'h80FF7F01);
        ua(3'b110, 2'd0, 32'h80FF7F01, 32'h00000000);

        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_mem_en", {31'd0, bus.mem_en}, 32'd0);
        rst_n = 1'b1;

        //    we    f3     addr          wdata         a       we       di            rdata         fault
        issue(1'b1, F3_W,  32'h00000010, 32'hDEADBEEF, 11'd4,  4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 1);
        issue(1'b0, F3_W,  32'h00000010, 32'h0,        11'd4,  4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 1);
        issue(1'b1, F3_B,  32'h00000013, 32'h00000080, 11'd4,  4'b1000, 32'h80808080, 32'h00000000, 1'b0, 1);
        issue(1'b0, F3_B,  32'h00000013, 32'h0,        11'd4,  4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 1);
        issue(1'b0, F3_BU, 32'h00000013, 32'h0,        11'd4,  4'b0000, 32'h0,        32'h00000080, 1'b0, 1);
        issue(1'b1, F3_H,  32'h00000022, 32'h12348001, 11'd8,  4'b1100, 32'h80018001, 32'h00000000, 1'b0, 1);
        issue(1'b0, F3_H,  32'h00000022, 32'h0,        11'd8,  4'b0000, 32'h0,        32'hFFFF8001, 1'b0, 1);
        issue(1'b0, F3_HU, 32'h00000022, 32'h0,        11'd8,  4'b0000, 32'h0,        32'h00008001, 1'b0, 1);
        issue(1'b0, 3'b110, 32'h00000010, 32'h0,       11'd0,  4'b0000, 32'h0,        32'h00000000, 1'b1, 1);
        issue(1'b1, 3'b011, 32'h00000010, 32'h55555555, 11'd0, 4'b0000, 32'h0,        32'h00000000, 1'b1, 1);
        issue(1'b0, F3_W,  32'h00000010, 32'h0,        11'd4,  4'b0000, 32'h0,        32'h80ADBEEF, 1'b0, 1);
        issue(1'b1, F3_W,  32'h00000004, 32'hCAFEF00D, 11'd1,  4'b1111, 32'hCAFEF00D, 32'h00000000, 1'b0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, F3_W,  32'h00000005, 32'h0,        11'd0,  4'b0000, 32'h0,        32'h00000000, 1'b1, 1);
        issue(1'b0, F3_HU, 32'h00000023, 32'h0,        11'd0,  4'b0000, 32'h0,        32'h00000000, 1'b1, 1);
`else
        issue(1'b0, F3_W,  32'h00000005, 32'h0,        11'd1,  4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 1);
        issue(1'b0, F3_HU, 32'h00000023, 32'h0,        11'd8,  4'b0000, 32'h0,        32'h00008001, 1'b0, 1);
`endif
        issue(1'b1, F3_B,  32'h00002010, 32'h000000A5, 11'd4,  4'b0001, 32'hA5A5A5A5, 32'h00000000, 1'b0, 1);
        issue(1'b0, F3_W,  32'h00000010, 32'h0,        11'd4,  4'b0000, 32'h0,        32'h80ADBEA5, 1'b0, 1);
        issue(1'b1, F3_H,  32'h00000006, 32'hFFFF7FFE, 11'd1,  4'b1100, 32'h7FFE7FFE, 32'h00000000, 1'b0, 1);
        issue(1'b0, F3_H,  32'h00000006, 32'h0,        11'd1,  4'b0000, 32'h0,        32'h00007FFE, 1'b0, 1);

        // Load aborted by reset while in WAIT: memory read happens, no response follows.
        issue(1'b0, F3_W,  32'h00000004, 32'h0,        11'd1,  4'b0000, 32'h0,        32'h0,        1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("abort_mem_drained", mem_q.size(), 32'd0);
        mem_q.delete();

        issue(1'b1, F3_W,  32'h00000030, 32'h11223344, 11'd12, 4'b1111, 32'h11223344, 32'h00000000, 1'b0, 1);
        issue(1'b0, F3_W,  32'h00000030, 32'h0,        11'd12, 4'b0000, 32'h0,        32'h11223344, 1'b0, 1);

        repeat (5) @(negedge clk);
        chk("rsp_queue_empty", rsp_q.size(), 32'd0);
        chk("mem_queue_empty", mem_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
